// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronise and deglitch ps2_clk, deserialise 11-bit frames,
// fold E0/F0 prefixes into tags and buffer scan codes in a valid/ready FIFO.
module ps2_rx_fifo #(
  parameter int DATA_W        = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_LEN    = 4,
  parameter int TIMEOUT_CYC   = 5000,
  parameter int DECODE_PREFIX = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_ext,
  output logic                          out_brk,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);
  localparam int BW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int EW  = DATA_W + 2;
  localparam bit PREFIX_EN = (DECODE_PREFIX != 0) && (DATA_W == 8);
  localparam logic [DATA_W-1:0] CODE_E0 = DATA_W'(8'hE0);
  localparam logic [DATA_W-1:0] CODE_F0 = DATA_W'(8'hF0);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
  logic                   filt_clk_q, filt_clk_d, filt_del_q, filt_del_d, fall_q, fall_d;
  logic [FCW-1:0]         filt_cnt_q, filt_cnt_d;
  state_t                 state_q, state_d;
  logic [DATA_W-1:0]      shift_q, shift_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic                   par_q, par_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
  logic [EW-1:0]          mem_q [FIFO_DEPTH];
  logic [EW-1:0]          mem_d [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;

  logic clk_s, data_s, pop, full, good, push_req, wr_en, perr, ferr, ovf;
  logic [EW-1:0] head;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      filt_clk_q  <= 1'b1;
      filt_del_q  <= 1'b1;
      filt_cnt_q  <= '0;
      fall_q      <= 1'b0;
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      par_q       <= 1'b0;
      tmo_q       <= '0;
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      filt_clk_q  <= filt_clk_d;
      filt_del_q  <= filt_del_d;
      filt_cnt_q  <= filt_cnt_d;
      fall_q      <= fall_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      par_q       <= par_d;
      tmo_q       <= tmo_d;
      ext_pend_q  <= ext_pend_d;
      brk_pend_q  <= brk_pend_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Front end: the filtered clock flips only after FILTER_LEN consecutive differing samples.
  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
    clk_s       = clk_sync_q[SYNC_STAGES-1];
    data_s      = data_sync_q[SYNC_STAGES-1];
    filt_clk_d  = filt_clk_q;
    filt_cnt_d  = '0;
    if (clk_s != filt_clk_q) begin
      if (filt_cnt_q == FCW'(FILTER_LEN - 1)) filt_clk_d = clk_s;
      else filt_cnt_d = filt_cnt_q + FCW'(1);
    end
    filt_del_d = filt_clk_q;
    fall_d     = filt_del_q & ~filt_clk_q;
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    par_d      = par_q;
    tmo_d      = '0;
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    good       = 1'b0;
    push_req   = 1'b0;
    wr_en      = 1'b0;
    perr       = 1'b0;
    ferr       = 1'b0;
    ovf        = 1'b0;
    pop        = (count_q != '0) && out_ready;
    full       = (count_q == CW'(FIFO_DEPTH));

    case (state_q)
      IDLE: begin
        if (fall_q && !data_s) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (fall_q) begin
          shift_d   = {data_s, shift_q[DATA_W-1:1]};
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == BW'(DATA_W - 1)) state_d = PARITY;
        end
      end
      PARITY: begin
        if (fall_q) begin
          par_d   = data_s;
          state_d = STOP;
        end
      end
      STOP: begin
        if (fall_q) begin
          state_d = IDLE;
          if (^{shift_q, par_q} != 1'b1) perr = 1'b1;
          else if (!data_s) ferr = 1'b1;
          else good = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE) begin
      if (fall_q) begin
        tmo_d = '0;
      end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
        ferr    = 1'b1;
        state_d = IDLE;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end

    // Prefix bytes only arm a tag; the following real byte carries and clears them.
    if (good) begin
      if (PREFIX_EN && shift_q == CODE_E0) ext_pend_d = 1'b1;
      else if (PREFIX_EN && shift_q == CODE_F0) brk_pend_d = 1'b1;
      else push_req = 1'b1;
    end
    if (push_req || perr || ferr) begin
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end

    if (push_req) begin
      if (!full || pop) wr_en = 1'b1;
      else ovf = 1'b1;
    end
    if (wr_en) begin
      mem_d[wr_ptr_q] = {shift_q, ext_pend_q, brk_pend_q};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(wr_en) - CW'(pop);
  end

  always_comb begin
    head       = mem_q[rd_ptr_q];
    out_valid  = (count_q != '0);
    out_data   = out_valid ? head[EW-1:2] : '0;
    out_ext    = out_valid & head[1];
    out_brk    = out_valid & head[0];
    parity_err = perr;
    frame_err  = ferr;
    overflow   = ovf;
    fifo_count = count_q;
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: a PS/2 frame driver plus a queue-based model of
// the decoded scan-code stream, prefix tags and error/overflow pulse counts.
module tb_ps2_rx_fifo;

   localparam int SYNC   = 2;
   localparam int FILT   = 4;
   localparam int TMO    = 5000;
   localparam int DEPTH  = 4;
   localparam int HALF   = 20;
   localparam int LAT    = SYNC + FILT + 2;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       ps2Clk = 1'b1;
   logic       ps2Data = 1'b1;
   logic       outReady = 1'b0;
   logic [7:0] outData;
   logic       outExt, outBrk, outValid, parityErr, frameErr, overflowPulse;
   logic [2:0] fifoCount;

   ps2_rx_fifo #(
      .DATA_W(8), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC), .FILTER_LEN(FILT),
      .TIMEOUT_CYC(TMO), .DECODE_PREFIX(1)
   ) dut (
      .clk(clock), .reset(reset), .ps2_clk(ps2Clk), .ps2_data(ps2Data),
      .out_data(outData), .out_ext(outExt), .out_brk(outBrk), .out_valid(outValid),
      .out_ready(outReady), .parity_err(parityErr), .frame_err(frameErr),
      .overflow(overflowPulse), .fifo_count(fifoCount)
   );

   // 50 MHz system clock
   always #10 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int obsPerr = 0, obsFerr = 0, obsOvf = 0, validCycles = 0, ferrCyc = 0;
   int expPerr = 0, expFerr = 0, expOvf = 0;
   int lastFallCyc = 0;
   logic [9:0] lastPop = '0;
   logic [9:0] modelQ[$];
   bit extM = 0, brkM = 0;

   // Free-running cycle stamp used to time the timeout pulse against the last raw edge
   always @(posedge clock) cyc <= cyc + 1;

   // Pulse monitor: counts every sampled cycle of each one-cycle pulse, slightly after
   // the falling edge so that out_ready changes made on that edge have settled
   always @(negedge clock) begin
      #2;
      if (parityErr) obsPerr++;
      if (frameErr) begin
         obsFerr++;
         ferrCyc = cyc;
      end
      if (overflowPulse) obsOvf++;
      if (outValid) validCycles++;
      if (outValid && outReady) lastPop = {outData, outExt, outBrk};
   end

   // Single comparison point for the whole bench
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic waitNeg(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Drive one 11-bit frame and update the reference model with what it should produce.
   // glitchBit inserts a 2-cycle low glitch before that bit's falling edge; popAtStop
   // pops the head in exactly the cycle the frame is written.
   task automatic applyStimulus(input logic [7:0] b, input bit badPar, input bit badStop,
                                input int glitchBit, input bit popAtStop);
      logic [10:0] bits;
      logic [9:0]  head;
      bit          good, wasEmpty;
      int          firstValid;
      bits = {~badStop, (~^b) ^ badPar, b, 1'b0};
      good = !badPar && !badStop && (b != 8'hE0) && (b != 8'hF0);
      wasEmpty = good && (modelQ.size() == 0);
      head = '0;
      if (popAtStop) head = modelQ[0];
      firstValid = -1;
      for (int i = 0; i < 11; i++) begin
         @(negedge clock);
         ps2Data = bits[i];
         waitNeg(HALF);
         if (glitchBit == i) begin
            ps2Clk = 1'b0;
            waitNeg(2);
            ps2Clk = 1'b1;
            waitNeg(HALF);
         end
         ps2Clk = 1'b0;
         for (int k = 1; k <= HALF; k++) begin
            @(negedge clock);
            if (i == 10) begin
               if (firstValid < 0 && outValid) firstValid = k;
               if (popAtStop && k == LAT - 1) begin
                  checkOutput("popHead", {22'd0, outData, outExt, outBrk}, {22'd0, head});
                  outReady = 1'b1;
               end
               if (popAtStop && k == LAT) outReady = 1'b0;
            end
         end
         ps2Clk = 1'b1;
      end
      ps2Data = 1'b1;
      waitNeg(HALF);
      if (badPar) begin
         expPerr++;
         extM = 0; brkM = 0;
      end else if (badStop) begin
         expFerr++;
         extM = 0; brkM = 0;
      end else if (b == 8'hE0) begin
         extM = 1;
      end else if (b == 8'hF0) begin
         brkM = 1;
      end else begin
         if (popAtStop) head = modelQ.pop_front();
         if (modelQ.size() < DEPTH) modelQ.push_back({b, extM, brkM});
         else expOvf++;
         extM = 0; brkM = 0;
      end
      if (wasEmpty) checkOutput("latency", firstValid, LAT);
   endtask

   // Drive a start bit plus nData payload bits, then leave the bus idle
   task automatic sendPartial(input logic [7:0] b, input int nData);
      logic [8:0] bits;
      bits = {b, 1'b0};
      for (int i = 0; i <= nData; i++) begin
         @(negedge clock);
         ps2Data = bits[i];
         waitNeg(HALF);
         ps2Clk = 1'b0;
         lastFallCyc = cyc;
         waitNeg(HALF);
         ps2Clk = 1'b1;
      end
      ps2Data = 1'b1;
   endtask

   task automatic popOne();
      logic [9:0] head;
      @(negedge clock);
      checkOutput("headValid", outValid, 1);
      checkOutput("headCount", fifoCount, modelQ.size());
      checkOutput("head", {22'd0, outData, outExt, outBrk}, {22'd0, modelQ[0]});
      outReady = 1'b1;
      @(negedge clock);
      outReady = 1'b0;
      head = modelQ.pop_front();
   endtask

   task automatic drainAll();
      while (modelQ.size() > 0) popOne();
      @(negedge clock);
      checkOutput("emptyValid", outValid, 0);
      checkOutput("emptyData", outData, 0);
      checkOutput("emptyCount", fifoCount, 0);
   endtask

   task automatic checkCounts();
      waitNeg(2);
      checkOutput("parityErrs", obsPerr, expPerr);
      checkOutput("frameErrs", obsFerr, expFerr);
      checkOutput("overflows", obsOvf, expOvf);
      checkOutput("count", fifoCount, modelQ.size());
   endtask

   // Directed scenarios first, then a randomized stream against the model
   initial begin
      int v0, f0, n, sel;
      logic [7:0] rb;
      bit bp, bs, pas;

      waitNeg(3);
      checkOutput("rstValid", outValid, 0);
      checkOutput("rstData", outData, 0);
      checkOutput("rstCount", fifoCount, 0);
      checkOutput("rstPulses", {parityErr, frameErr, overflowPulse, outExt, outBrk}, 0);
      reset = 1'b1;
      waitNeg(5);

      $display("[TB] single frame with out_ready high");
      outReady = 1'b1;
      v0 = validCycles;
      applyStimulus(8'h1C, 0, 0, -1, 0);
      outReady = 1'b0;
      waitNeg(2);
      checkOutput("t1ValidCycles", validCycles - v0, 1);
      checkOutput("t1Popped", lastPop, {8'h1C, 2'b00});
      modelQ.delete();
      checkCounts();

      $display("[TB] parity error then good frame");
      applyStimulus(8'h1C, 1, 0, -1, 0);
      checkOutput("t2NoValid", outValid, 0);
      applyStimulus(8'h32, 0, 0, -1, 0);
      checkCounts();
      drainAll();

      $display("[TB] prefix folding");
      applyStimulus(8'hE0, 0, 0, -1, 0);
      applyStimulus(8'hF0, 0, 0, -1, 0);
      applyStimulus(8'h74, 0, 0, -1, 0);
      applyStimulus(8'h74, 0, 0, -1, 0);
      checkCounts();
      drainAll();

      $display("[TB] fill and overflow");
      applyStimulus(8'h15, 0, 0, -1, 0);
      applyStimulus(8'h1D, 0, 0, -1, 0);
      applyStimulus(8'h24, 0, 0, -1, 0);
      applyStimulus(8'h2D, 0, 0, -1, 0);
      applyStimulus(8'h2C, 0, 0, -1, 0);
      checkCounts();
      applyStimulus(8'h3C, 0, 0, -1, 1);
      checkCounts();
      drainAll();

      $display("[TB] inter-bit timeout");
      sendPartial(8'h5A, 4);
      f0 = obsFerr;
      n = 0;
      while (obsFerr == f0 && n < TMO + 200) begin
         @(negedge clock);
         n++;
      end
      waitNeg(2);
      checkOutput("timeoutSeen", obsFerr, f0 + 1);
      checkOutput("timeoutCyc", ferrCyc - lastFallCyc, TMO + SYNC + FILT + 1);
      expFerr++;
      extM = 0; brkM = 0;
      applyStimulus(8'h29, 0, 0, -1, 0);
      checkCounts();
      drainAll();

      $display("[TB] clock glitches, stop error and reset mid-frame");
      @(negedge clock);
      ps2Clk = 1'b0;
      waitNeg(2);
      ps2Clk = 1'b1;
      waitNeg(HALF);
      applyStimulus(8'h4B, 0, 0, 4, 0);
      applyStimulus(8'hE0, 0, 0, -1, 0);
      applyStimulus(8'h4B, 0, 1, -1, 0);
      applyStimulus(8'h11, 0, 0, -1, 0);
      applyStimulus(8'h22, 0, 0, -1, 0);
      checkCounts();
      sendPartial(8'h33, 3);
      @(negedge clock);
      reset = 1'b0;
      waitNeg(2);
      checkOutput("midRstValid", outValid, 0);
      checkOutput("midRstCount", fifoCount, 0);
      checkOutput("midRstData", outData, 0);
      reset = 1'b1;
      modelQ.delete();
      extM = 0; brkM = 0;
      waitNeg(5);
      applyStimulus(8'h1C, 0, 0, -1, 0);
      checkCounts();
      drainAll();

      $display("[TB] randomized stream");
      for (int it = 0; it < 30; it++) begin
         sel = $urandom_range(0, 7);
         if (sel == 0) rb = 8'hE0;
         else if (sel == 1) rb = 8'hF0;
         else rb = 8'($urandom_range(0, 255));
         bp = ($urandom_range(0, 7) == 0);
         bs = ($urandom_range(0, 7) == 0);
         pas = (modelQ.size() == DEPTH) && !bp && !bs && rb != 8'hE0 && rb != 8'hF0
               && ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 3) == 0) begin
            n = $urandom_range(1, 3);
            for (int p = 0; p < n; p++)
               if (modelQ.size() > 0) popOne();
         end
         applyStimulus(rb, bp, bs, -1, pas);
      end
      checkCounts();
      drainAll();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
